// File: rtl/command_master_uart.sv
// command_master_uart
//   Host-side initiator for the UART register-access protocol. Turns a
//   parallel write/read request into the byte stream expected by the
//   register-side command parser:
//     write: OP_WRITE, addr, data byte 0 .. data byte VALUE_WORDS-1 (LE)
//     read : OP_READ,  addr, then collects VALUE_WORDS LE response bytes
//   A read either completes with o_rsp_valid/o_rsp_data or aborts with
//   o_rsp_timeout when the gap between response bytes grows too long.
//
// Ports
//   clk, i_reset_n              clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake (ready only in IDLE)
//   i_req_write                 1 = write, 0 = read
//   i_req_addr, i_req_data      request address / write value
//   o_tx_data/o_tx_valid/i_tx_ready  byte stream to the UART transmitter
//   i_rx_data/i_rx_dv           bytes from the UART receiver
//   o_rsp_valid, o_rsp_data     read word, one-cycle pulse
//   o_rsp_timeout               read aborted, one-cycle pulse
//   o_wr_done                   last write byte accepted, one-cycle pulse
//   o_rx_unexpected             byte arrived while not awaiting a response
module command_master_uart #(
  parameter int                    WORD_WIDTH     = 8,
  parameter int                    VALUE_WORDS    = 4,
  parameter logic [WORD_WIDTH-1:0] OP_WRITE       = 8'h57,
  parameter logic [WORD_WIDTH-1:0] OP_READ        = 8'h52,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                              clk,
  input  logic                              i_reset_n,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic                              i_req_write,
  input  logic [WORD_WIDTH-1:0]             i_req_addr,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_req_data,
  output logic [WORD_WIDTH-1:0]             o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  input  logic [WORD_WIDTH-1:0]             i_rx_data,
  input  logic                              i_rx_dv,
  output logic                              o_rsp_valid,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0] o_rsp_data,
  output logic                              o_rsp_timeout,
  output logic                              o_wr_done,
  output logic                              o_rx_unexpected
);

  localparam int IDX_W = (VALUE_WORDS > 1) ? $clog2(VALUE_WORDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VALUE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_OP   = 3'd1;
  localparam logic [2:0] S_SEND_ADDR = 3'd2;
  localparam logic [2:0] S_SEND_DATA = 3'd3;
  localparam logic [2:0] S_WAIT_RSP  = 3'd4;

  logic [2:0]                                state;
  logic                                      write_q;
  logic [WORD_WIDTH-1:0]                     addr_q;
  logic [VALUE_WORDS-1:0][WORD_WIDTH-1:0]    data_q;
  logic [VALUE_WORDS-1:0][WORD_WIDTH-1:0]    shadow;
  logic [VALUE_WORDS-1:0][WORD_WIDTH-1:0]    rsp_word;
  logic [IDX_W-1:0]                          idx;
  logic [IDX_W-1:0]                          idx_next;
  logic [CNT_W-1:0]                          cnt;
  logic                                      tx_fire;

  assign tx_fire  = o_tx_valid && i_tx_ready;
  assign idx_next = idx + 1'b1;

  // Shadow word with the byte arriving this cycle merged in; lets the last
  // response byte go straight to o_rsp_data without an extra cycle.
  always_comb begin
    rsp_word      = shadow;
    rsp_word[idx] = i_rx_data;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= S_IDLE;
      o_req_ready     <= 1'b1;
      o_tx_valid      <= 1'b0;
      o_tx_data       <= '0;
      o_rsp_valid     <= 1'b0;
      o_rsp_timeout   <= 1'b0;
      o_wr_done       <= 1'b0;
      o_rx_unexpected <= 1'b0;
      o_rsp_data      <= '0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      shadow          <= '0;
      idx             <= '0;
      cnt             <= '0;
    end else begin
      o_rsp_valid     <= 1'b0;
      o_rsp_timeout   <= 1'b0;
      o_wr_done       <= 1'b0;
      // Bytes outside a read response are dropped but flagged.
      o_rx_unexpected <= i_rx_dv && (state != S_WAIT_RSP);

      case (state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            write_q     <= i_req_write;
            addr_q      <= i_req_addr;
            data_q      <= i_req_data;
            o_req_ready <= 1'b0;
            o_tx_valid  <= 1'b1;
            o_tx_data   <= i_req_write ? OP_WRITE : OP_READ;
            state       <= S_SEND_OP;
          end
        end

        S_SEND_OP: begin
          if (tx_fire) begin
            o_tx_data <= addr_q;
            state     <= S_SEND_ADDR;
          end
        end

        S_SEND_ADDR: begin
          if (tx_fire) begin
            idx <= '0;
            if (write_q) begin
              o_tx_data <= data_q[0];
              state     <= S_SEND_DATA;
            end else begin
              o_tx_valid <= 1'b0;
              cnt        <= '0;
              state      <= S_WAIT_RSP;
            end
          end
        end

        S_SEND_DATA: begin
          if (tx_fire) begin
            if (idx == LAST_IDX) begin
              o_tx_valid  <= 1'b0;
              o_wr_done   <= 1'b1;
              o_req_ready <= 1'b1;
              idx         <= '0;
              state       <= S_IDLE;
            end else begin
              idx       <= idx_next;
              o_tx_data <= data_q[idx_next];
            end
          end
        end

        S_WAIT_RSP: begin
          // A received byte takes priority over the timeout terminal count.
          if (i_rx_dv) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              o_rsp_data  <= rsp_word;
              o_rsp_valid <= 1'b1;
              o_req_ready <= 1'b1;
              idx         <= '0;
              state       <= S_IDLE;
            end else begin
              shadow <= rsp_word;
              idx    <= idx_next;
            end
          end else if (cnt == CNT_TERM) begin
            // Partial bytes stay in shadow but are overwritten by the next read.
            o_rsp_timeout <= 1'b1;
            o_req_ready   <= 1'b1;
            idx           <= '0;
            cnt           <= '0;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          o_tx_valid  <= 1'b0;
          o_req_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_master_uart.sv
`timescale 1ns/1ps
// Testbench for command_master_uart: directed scenarios plus randomized
// writes/reads; expected tx bytes and response events are queued by the
// driver and consumed by an independent negedge monitor.
module tb_command_master_uart;

  localparam int WW  = 8;
  localparam int VW  = 4;
  localparam int TO  = 50;
  localparam logic [7:0] OPW = 8'h57;
  localparam logic [7:0] OPR = 8'h52;

  localparam int EV_WR  = 0;
  localparam int EV_RSP = 1;
  localparam int EV_TO  = 2;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [WW-1:0] i_req_addr = '0;
  logic [31:0]   i_req_data = '0;
  logic [WW-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b1;
  logic [WW-1:0] i_rx_data = '0;
  logic          i_rx_dv = 1'b0;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_data;
  logic          o_rsp_timeout;
  logic          o_wr_done;
  logic          o_rx_unexpected;

  command_master_uart #(
    .WORD_WIDTH(WW), .VALUE_WORDS(VW), .OP_WRITE(OPW), .OP_READ(OPR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_rx_data(i_rx_data), .i_rx_dv(i_rx_dv),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout), .o_wr_done(o_wr_done),
    .o_rx_unexpected(o_rx_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_exp[$];
  int          evt_kind[$];
  logic [31:0] evt_data[$];
  int          exp_unexp = 0;
  logic [31:0] last_word = '0;
  int          tx_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter ready pattern: 0 = always, 1 = one cycle in three, 2 = random.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (tx_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (cyc % 3 == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic expect_evt(input int kind, input string name);
    int k;
    logic [31:0] d;
    if (evt_kind.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got pulse expected none pending", name);
    end else begin
      k = evt_kind.pop_front();
      d = evt_data.pop_front();
      check({name, "_kind"}, kind, k);
      if (kind != EV_WR) check({name, "_data"}, o_rsp_data, d);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [31:0] prev_rsp  = '0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        prev_hold = 1'b0;
        prev_rsp  = o_rsp_data;
      end else begin
        if (prev_hold) begin
          check("tx_hold_valid", o_tx_valid, 1);
          check("tx_hold_data", o_tx_data, prev_data);
        end
        if (o_tx_valid && i_tx_ready) begin
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_extra: got byte %h expected no byte", o_tx_data);
          end else begin
            check("tx_byte", o_tx_data, tx_exp.pop_front());
          end
        end
        prev_hold = o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;

        if (o_rsp_valid || o_rsp_timeout || o_wr_done)
          check("pulse_exclusive", 32'(o_rsp_valid) + 32'(o_rsp_timeout) + 32'(o_wr_done), 1);
        if (o_wr_done)     expect_evt(EV_WR, "wr_done");
        if (o_rsp_valid)   expect_evt(EV_RSP, "rsp_valid");
        if (o_rsp_timeout) expect_evt(EV_TO, "rsp_timeout");

        if (o_rsp_data !== prev_rsp) check("rsp_data_with_valid", o_rsp_valid, 1);
        prev_rsp = o_rsp_data;

        if (o_rx_unexpected) begin
          check("rx_unexpected_pending", exp_unexp > 0, 1);
          if (exp_unexp > 0) exp_unexp--;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_req_ready && n < 300) begin
      tick();
      n++;
    end
    check(name, n < 300, 1);
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    wait_ready("req_ready_wait");
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_data  = data;
    tx_exp.push_back(wr ? OPW : OPR);
    tx_exp.push_back(addr);
    if (wr) begin
      for (int k = 0; k < VW; k++) tx_exp.push_back(data[8*k +: 8]);
      evt_kind.push_back(EV_WR);
      evt_data.push_back('0);
    end
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
    int n = 0;
    issue(1'b1, addr, data);
    check("req_ready_drop", o_req_ready, 0);
    while (!o_req_ready && n < 300) begin
      tick();
      n++;
    end
    check("wr_complete", n < 300, 1);
    // Opcode, address and VW data bytes back-to-back when ready stays high.
    if (tx_mode == 0) check("wr_latency", n, 2 + VW);
  endtask

  // Sends the low nbytes of word as LE response bytes; gap < 0 means random.
  task automatic do_read(input logic [7:0] addr, input logic [31:0] word,
                         input int nbytes, input int gap);
    int n = 0;
    int c = 0;
    issue(1'b0, addr, '0);
    while (tx_exp.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("rd_cmd_sent", n < 300, 1);
    if (nbytes == VW) begin
      evt_kind.push_back(EV_RSP);
      evt_data.push_back(word);
      last_word = word;
    end else begin
      evt_kind.push_back(EV_TO);
      evt_data.push_back(last_word);
    end
    for (int k = 0; k < nbytes; k++) begin
      repeat ((gap < 0) ? $urandom_range(0, 20) : gap) tick();
      i_rx_dv   = 1'b1;
      i_rx_data = word[8*k +: 8];
      tick();
      i_rx_dv   = 1'b0;
    end
    if (nbytes < VW) begin
      while (!o_rsp_timeout && c < 300) begin
        tick();
        c++;
      end
      check("timeout_latency", c, TO);
    end
    wait_ready("rd_complete");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", o_req_ready, 1);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_rsp_data", o_rsp_data, 0);
    check("rst_pulses", {o_rsp_valid, o_rsp_timeout, o_wr_done, o_rx_unexpected}, 0);
    i_reset_n = 1'b1;
    tick();

    // Directed write, back-to-back then throttled
    tx_mode = 0;
    do_write(8'h05, 32'hDEADBEEF);
    tx_mode = 1;
    do_write(8'h05, 32'hDEADBEEF);
    tx_mode = 0;

    // Directed read with 10-cycle gaps
    do_read(8'h12, 32'h12345678, VW, 10);
    check("rsp_word_direct", o_rsp_data, 32'h12345678);

    // Timeout after two bytes; word must be unchanged, then a clean read
    do_read(8'h34, 32'hCAFE0000 | 32'($urandom_range(0, 65535)), 2, 5);
    check("rsp_kept_after_timeout", o_rsp_data, 32'h12345678);
    d = $urandom;
    do_read(8'h35, d, VW, -1);
    check("rsp_after_timeout", o_rsp_data, d);

    // Unexpected byte while idle
    exp_unexp++;
    i_rx_dv   = 1'b1;
    i_rx_data = 8'hAA;
    tick();
    i_rx_dv   = 1'b0;
    tick();
    check("unexp_still_idle", o_req_ready, 1);
    check("unexp_consumed", exp_unexp, 0);

    // Randomized mix
    for (int i = 0; i < 24; i++) begin
      tx_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom), $urandom);
      else                           do_read(8'($urandom), $urandom, VW, -1);
      if ($urandom_range(0, 4) == 0) begin
        exp_unexp++;
        i_rx_dv   = 1'b1;
        i_rx_data = 8'($urandom);
        tick();
        i_rx_dv   = 1'b0;
      end
    end

    // Reset while data byte 2 is being presented
    tx_mode = 0;
    d = 32'hA1B2C3D4;
    issue(1'b1, 8'h77, d);
    repeat (4) tick();
    check("pre_rst_byte2", o_tx_data, d[23:16]);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("rst_async_tx_valid", o_tx_valid, 0);
    check("rst_async_rsp_data", o_rsp_data, 0);
    tx_exp.delete();
    evt_kind.delete();
    evt_data.delete();
    last_word = '0;
    repeat (2) tick();
    i_reset_n = 1'b1;
    tick();
    check("post_rst_ready", o_req_ready, 1);
    do_write(8'h09, 32'h0BADF00D);
    d = $urandom;
    do_read(8'h0A, d, VW, -1);
    check("post_rst_read", o_rsp_data, d);

    repeat (5) tick();
    check("tx_queue_empty", tx_exp.size(), 0);
    check("evt_queue_empty", evt_kind.size(), 0);
    check("unexp_queue_empty", exp_unexp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
